// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight writers in a WB_DEPTH-deep shift register and
// stalls ID per source operand (load-use only with forwarding, full interlock without).
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int WB_DEPTH    = 3,
    parameter int FORWARD_EN  = 1,
    parameter int LOAD_LAT    = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   ID_Valid,
    input  logic                   ID_UsesRs,
    input  logic                   ID_UsesRt,
    input  logic [REG_ADDR_W-1:0]  ID_RegisterRs,
    input  logic [REG_ADDR_W-1:0]  ID_RegisterRt,
    input  logic                   ID_RegWrite,
    input  logic [REG_ADDR_W-1:0]  ID_RegisterRd,
    input  logic                   ID_MemRead,
    input  logic                   Flush,
    output logic                   PCWrite,
    output logic                   IF_ID_Write,
    output logic                   ControlHazard,
    output logic [STALL_CNT_W-1:0] StallCount
);

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] rd;
        logic                  load;
    } slot_t;

    slot_t [WB_DEPTH-1:0]   slot_q, slot_d;
    logic  [WB_DEPTH-1:0]   match;
    logic                   hazard;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    // Register 0 is hardwired, so a writer to it never blocks a reader.
    always_comb begin
        match  = '0;
        hazard = 1'b0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            match[k] = slot_q[k].vld && (slot_q[k].rd != '0) &&
                       ((ID_UsesRs && (slot_q[k].rd == ID_RegisterRs)) ||
                        (ID_UsesRt && (slot_q[k].rd == ID_RegisterRt)));
            if (FORWARD_EN != 0) begin
                if ((k < LOAD_LAT) && match[k] && slot_q[k].load) hazard = 1'b1;
            end else if (match[k]) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && ID_Valid && !Flush;
    end

    always_comb begin
        slot_d = '0;
        if (ID_Valid && ID_RegWrite && !hazard && !Flush) begin
            slot_d[0].vld  = 1'b1;
            slot_d[0].rd   = ID_RegisterRd;
            slot_d[0].load = ID_MemRead;
        end
        // A flush also squashes the instruction now in EX, so it never reaches slot 1.
        for (int k = 1; k < WB_DEPTH; k++) begin
            if ((k == 1) && Flush) slot_d[k] = '0;
            else                   slot_d[k] = slot_q[k-1];
        end
        cnt_d = cnt_q;
        if (hazard && (cnt_q != '1)) cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slot_q <= '0;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ControlHazard = hazard;
    assign PCWrite       = ~hazard;
    assign IF_ID_Write   = ~hazard;
    assign StallCount    = cnt_q;

endmodule
